// File: rtl/alsu_cmd_sequencer.sv
// ALSU command sequencer: buffers packed commands, drives the ALSU pins from
// registers, tracks each issued command through the fixed ALSU latency and
// returns results with their tags through a response FIFO.
module alsu_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned ALSU_LAT  = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [16:0]      cmd_data,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alsu_opcode,
  output logic [2:0]       alsu_A,
  output logic [2:0]       alsu_B,
  output logic             alsu_cin,
  output logic             alsu_serial_in,
  output logic             alsu_red_op_A,
  output logic             alsu_red_op_B,
  output logic             alsu_bypass_A,
  output logic             alsu_bypass_B,
  output logic             alsu_direction,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_out,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_invalid
);

  localparam int unsigned CPW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CCW = CPW + 1;
  localparam int unsigned RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RCW = RPW + 1;

  // Command FIFO storage; bit 0 of cmd_data is reserved and not stored.
  logic [16:1]      cmd_dmem [CMD_DEPTH];
  logic [TAG_W-1:0] cmd_tmem [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wr, cmd_rd;
  logic [CCW-1:0]   cmd_count;
  logic             cmd_push, issue;
  logic [16:1]      head_d;
  logic [TAG_W-1:0] head_t;
  logic             head_inv;

  // Response FIFO storage
  logic [5:0]       rsp_omem [RSP_DEPTH];
  logic [TAG_W-1:0] rsp_tmem [RSP_DEPTH];
  logic             rsp_imem [RSP_DEPTH];
  logic [RPW-1:0]   rsp_wr, rsp_rd;
  logic [RCW-1:0]   rsp_count;
  logic             rsp_push, rsp_pop;

  // Tag pipeline mirroring the ALSU latency plus the input register stage
  logic [ALSU_LAT:0] pipe_v;
  logic [ALSU_LAT:0] pipe_inv;
  logic [TAG_W-1:0]  pipe_tag [ALSU_LAT+1];

  logic [31:0] inflight;
  logic [31:0] used;

  logic unused_reserved;
  assign unused_reserved = cmd_data[0];

  assign cmd_ready = !reset && (cmd_count != CCW'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;

  assign head_d   = cmd_dmem[cmd_rd];
  assign head_t   = cmd_tmem[cmd_rd];
  assign head_inv = (head_d[16:14] == 3'd6) || (head_d[16:14] == 3'd7) ||
                    ((head_d[5] || head_d[4]) && (head_d[16:14] >= 3'd2));

  // Credit check: a result slot is reserved for every command still in flight
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= ALSU_LAT; i++) begin
      inflight = inflight + 32'(pipe_v[i]);
    end
    used  = 32'(rsp_count) + inflight;
    issue = (cmd_count != '0) && (used < RSP_DEPTH);
  end

  // Command FIFO payload write
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_dmem[cmd_wr] <= cmd_data[16:1];
      cmd_tmem[cmd_wr] <= cmd_tag;
    end
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + CPW'(1);
      if (issue)    cmd_rd <= cmd_rd + CPW'(1);
      case ({cmd_push, issue})
        2'b10:   cmd_count <= cmd_count + CCW'(1);
        2'b01:   cmd_count <= cmd_count - CCW'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // ALSU drive registers: load the head command on issue, otherwise all zero
  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      alsu_opcode    <= '0;
      alsu_A         <= '0;
      alsu_B         <= '0;
      alsu_cin       <= 1'b0;
      alsu_serial_in <= 1'b0;
      alsu_red_op_A  <= 1'b0;
      alsu_red_op_B  <= 1'b0;
      alsu_bypass_A  <= 1'b0;
      alsu_bypass_B  <= 1'b0;
      alsu_direction <= 1'b0;
    end else begin
      alsu_opcode    <= head_d[16:14];
      alsu_A         <= head_d[13:11];
      alsu_B         <= head_d[10:8];
      alsu_cin       <= head_d[7];
      alsu_serial_in <= head_d[6];
      alsu_red_op_A  <= head_d[5];
      alsu_red_op_B  <= head_d[4];
      alsu_bypass_A  <= head_d[3];
      alsu_bypass_B  <= head_d[2];
      alsu_direction <= head_d[1];
    end
  end

  // Tag pipeline shifts every cycle; stage 0 records whether this cycle issued
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v   <= '0;
      pipe_inv <= '0;
      for (int unsigned i = 0; i <= ALSU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v      <= {pipe_v[ALSU_LAT-1:0], issue};
      pipe_inv    <= {pipe_inv[ALSU_LAT-1:0], head_inv};
      pipe_tag[0] <= head_t;
      for (int unsigned i = 1; i <= ALSU_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  assign rsp_push = pipe_v[ALSU_LAT];
  assign rsp_pop  = rsp_valid && rsp_ready;

  // Response FIFO payload write: capture the ALSU result as its tag retires
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_omem[rsp_wr] <= alsu_out;
      rsp_tmem[rsp_wr] <= pipe_tag[ALSU_LAT];
      rsp_imem[rsp_wr] <= pipe_inv[ALSU_LAT];
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wr    <= '0;
      rsp_rd    <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) rsp_wr <= rsp_wr + RPW'(1);
      if (rsp_pop)  rsp_rd <= rsp_rd + RPW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + RCW'(1);
        2'b01:   rsp_count <= rsp_count - RCW'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Head of the response FIFO, forced to zero while empty or in reset
  always_comb begin
    rsp_valid   = !reset && (rsp_count != '0);
    rsp_out     = '0;
    rsp_tag     = '0;
    rsp_invalid = 1'b0;
    if (rsp_valid) begin
      rsp_out     = rsp_omem[rsp_rd];
      rsp_tag     = rsp_tmem[rsp_rd];
      rsp_invalid = rsp_imem[rsp_rd];
    end
  end

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Scoreboard bench for alsu_cmd_sequencer with a behavioural two-stage ALSU.
module tb_alsu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [16:0] cmd_data;
  logic [3:0] cmd_tag;
  logic [2:0] alsu_opcode, alsu_A, alsu_B;
  logic       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic       alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0] alsu_out;
  logic       rsp_valid, rsp_ready, rsp_invalid;
  logic [5:0] rsp_out;
  logic [3:0] rsp_tag;

  always #5 clk = ~clk;

  alsu_cmd_sequencer #(
    .CMD_DEPTH(4),
    .RSP_DEPTH(4),
    .ALSU_LAT (2),
    .TAG_W    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .cmd_tag       (cmd_tag),
    .alsu_opcode   (alsu_opcode),
    .alsu_A        (alsu_A),
    .alsu_B        (alsu_B),
    .alsu_cin      (alsu_cin),
    .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A (alsu_red_op_A),
    .alsu_red_op_B (alsu_red_op_B),
    .alsu_bypass_A (alsu_bypass_A),
    .alsu_bypass_B (alsu_bypass_B),
    .alsu_direction(alsu_direction),
    .alsu_out      (alsu_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_out       (rsp_out),
    .rsp_tag       (rsp_tag),
    .rsp_invalid   (rsp_invalid)
  );

  typedef struct packed {
    logic [5:0] out;
    logic [3:0] tag;
    logic       inv;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned pop_cyc[$];
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  int unsigned n_pop    = 0;
  int unsigned cyc      = 0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ALSU behaviour for the operations exercised here: {invalid, out}
  function automatic logic [6:0] alsu_fn(input logic [2:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic cin,
                                         input logic ra, input logic rb);
    logic       inv;
    logic [5:0] o;
    inv = (op == 3'd6) || (op == 3'd7) || ((ra || rb) && (op >= 3'd2));
    o = '0;
    if (!inv) begin
      case (op)
        3'd0:    o = {3'b0, a | b};
        3'd1:    o = {3'b0, a ^ b};
        3'd2:    o = 6'(a) + 6'(b) + 6'(cin);
        3'd3:    o = 6'(a) * 6'(b);
        default: o = '0;
      endcase
    end
    return {inv, o};
  endfunction

  // Behavioural ALSU: registered inputs, registered output
  logic [2:0] q_op, q_a, q_b;
  logic       q_cin, q_ra, q_rb;
  always @(posedge clk) begin
    q_op  <= alsu_opcode;
    q_a   <= alsu_A;
    q_b   <= alsu_B;
    q_cin <= alsu_cin;
    q_ra  <= alsu_red_op_A;
    q_rb  <= alsu_red_op_B;
    alsu_out <= 6'(alsu_fn(q_op, q_a, q_b, q_cin, q_ra, q_rb));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every accepted response is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_t e;
      chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_out", 32'(rsp_out), 32'(e.out));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_invalid", 32'(rsp_invalid), 32'(e.inv));
      end
      n_pop++;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic cin, input logic ra, input logic [3:0] tag,
                      input logic [5:0] exp_out, input logic exp_inv,
                      output int unsigned stalls);
    bit done;
    cmd_data  = {op, a, b, cin, 1'b0, ra, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    stalls    = 0;
    done      = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back('{out: exp_out, tag: tag, inv: exp_inv});
        done = 1'b1;
      end else begin
        stalls++;
      end
      tick();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  function automatic logic [15:0] alsu_bus();
    return {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
            alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  s_op [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [2:0]  s_a  [4] = '{3'd1, 3'd3, 3'd2, 3'd1};
    logic [2:0]  s_b  [4] = '{3'd2, 3'd1, 3'd3, 3'd1};
    logic [5:0]  s_e  [4] = '{6'd3, 6'd2, 6'd6, 6'd2};
    int unsigned st, tot, p0;
    logic [6:0]  e;
    logic [2:0]  op, a, b;
    logic        cin;
    int unsigned r;

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_tag = '0; rsp_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alsu", 32'(alsu_bus()), 32'd0);
    chk("reset_rsp_fields", 32'({rsp_out, rsp_tag, rsp_invalid}), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single add: 3 + 2 + 1 = 6, tag 5
    send(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 4'd5, 6'd6, 1'b0, st);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("add_alsu_pre", 32'(alsu_opcode), 32'd0);
    tick();
    @(negedge clk);
    chk("add_alsu_drive", 32'({alsu_opcode, alsu_A, alsu_B, alsu_cin}),
        32'({3'd2, 3'd3, 3'd2, 1'b1}));
    tick();
    tick();
    @(negedge clk);
    chk("add_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    drain();

    // Back-to-back stream
    pop_cyc.delete();
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      send(s_op[i], s_a[i], s_b[i], 1'b0, 1'b0, 4'(i), s_e[i], 1'b0, st);
      tot += st;
    end
    cmd_valid = 1'b0;
    chk("stream_stalls", tot, 32'd0);
    drain();
    chk("stream_pops", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (pop_cyc.size() == 4) chk("stream_gap", pop_cyc[i] - pop_cyc[i-1], 32'd1);
    end

    // Invalid commands
    send(3'd6, 3'd3, 3'd1, 1'b0, 1'b0, 4'hA, 6'd0, 1'b1, st);
    send(3'd3, 3'd2, 3'd3, 1'b0, 1'b1, 4'hB, 6'd0, 1'b1, st);
    cmd_valid = 1'b0;
    drain();

    // Backpressure: 4 results held by credits, 4 more buffered
    rsp_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      send(3'd1, 3'(i), 3'd5, 1'b0, 1'b0, 4'(i), 6'(3'(i) ^ 3'd5), 1'b0, st);
    end
    cmd_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head_tag", 32'(rsp_tag), 32'd0);
    chk("bp_alsu_idle", 32'(alsu_bus()), 32'd0);
    chk("bp_no_pop", n_pop - p0, 32'd0);
    tick();
    rsp_ready = 1'b1;
    drain();
    chk("bp_drained", n_pop - p0, 32'd8);

    // Reset with commands in flight and queued
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 3'(i), 3'd0, 1'b0, 1'b0, 4'(i + 4), 6'(i), 1'b0, st);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alsu", 32'(alsu_bus()), 32'd0);
    tick();
    reset = 1'b0;
    p0 = n_pop;
    repeat (8) tick();
    @(negedge clk);
    chk("rst_no_stale", n_pop - p0, 32'd0);
    tick();
    send(3'd0, 3'd5, 3'd2, 1'b0, 1'b0, 4'd9, 6'd7, 1'b0, st);
    cmd_valid = 1'b0;
    drain();
    chk("rst_fresh", n_pop - p0, 32'd1);

    // Wrap-around with random response backpressure
    rand_rdy = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 12; i++) begin
      r   = $urandom_range(0, 5);
      op  = (r < 4) ? 3'(r) : 3'(r + 2);
      a   = 3'($urandom_range(0, 7));
      b   = 3'($urandom_range(0, 7));
      cin = 1'($urandom_range(0, 1));
      e   = alsu_fn(op, a, b, cin, 1'b0, 1'b0);
      send(op, a, b, cin, 1'b0, 4'(i), e[5:0], e[6], st);
    end
    cmd_valid = 1'b0;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("wrap_count", n_pop - p0, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
